rpsc_fault_annunciator: RTL and testbench
=========================================

Name: rpsc_fault_annunciator

Overview:
- Reads the latched-alarm (LA) lines of the fault latch cards (FF1..FF48) and captures the first fault, with lowest index winning ties.
- Maintains a live count of latched faults.
- On operator acknowledge, issues a timed reset pulse back to the latch cards, then verifies that all latches cleared.
- Sits beside the fault latch cards and replaces the free-running reset into them with a sequenced, verified clear.

Parameters:
- N_FF, 48, number of latched-alarm inputs; bit k corresponds to FF(k+1).
- RST_PULSE, 16, cycles o_ff_reset is held high (1..255).
- VERIFY_CYCLES, 8, settle cycles after the pulse before the all-clear check (1..255).

Ports:
- clk, input, 1, system clock.
- reset, input, 1, asynchronous active-low reset.
- i_ff_la, input, N_FF, latched-alarm lines, 1 = fault latched; asynchronous to clk.
- i_ack_req, input, 1, operator reset/acknowledge request, level; asynchronous to clk.
- o_ff_reset, output, 1, reset pulse to the latch cards, active-high.
- o_any_fault, output, 1, OR of the synchronized LA lines.
- o_fault_count, output, $clog2(N_FF+1), number of synchronized LA lines set.
- o_first_valid, output, 1, a first fault is held.
- o_first_idx, output, $clog2(N_FF), index of the first fault.
- o_busy, output, 1, reset pulse or verify in progress.
- o_clear_fail, output, 1, the last verify found latches still set.

Behaviour:
- Reset (reset=0, asynchronous):
  - All outputs are 0, synchronizers are 0, state is IDLE, counters are 0.
- Input conditioning:
  - Every bit of i_ff_la and i_ack_req passes through a 2-flop synchronizer; "la_s" and "ack_s" are the synchronized values.
  - ack_edge is asserted for one cycle on an ack_s 0->1 transition.
  - o_any_fault and o_fault_count are registered from la_s, giving 1 cycle beyond sync (3 cycles from pin).
- FSM states: IDLE, FAULT, PULSE, VERIFY, FAIL.
  - IDLE, la_s != 0:
    - Capture o_first_idx = lowest set index of la_s and set o_first_valid.
    - Go to FAULT.
    - Pin-to-o_first_valid latency is 3 cycles.
    - Several bits rising in the same cycle resolve to the lowest index.
  - IDLE, ack_edge: ignored.
  - FAULT:
    - Later faults never overwrite o_first_idx.
    - On ack_edge, go to PULSE and load the counter with RST_PULSE.
  - PULSE:
    - o_ff_reset=1 and o_busy=1.
    - The counter decrements each cycle; o_ff_reset is high for exactly RST_PULSE cycles.
    - At 0, go to VERIFY and load VERIFY_CYCLES.
  - VERIFY:
    - o_busy=1, o_ff_reset=0.
    - The counter runs for exactly VERIFY_CYCLES cycles, then la_s is sampled on the final cycle.
    - la_s == 0: clear o_first_valid, o_first_idx and o_clear_fail, then go to IDLE.
    - la_s != 0: set o_clear_fail and go to FAIL. o_first_idx keeps the original capture.
  - FAIL:
    - Holds the first-fault state.
    - On ack_edge, go to PULSE; o_clear_fail stays 1 until a verify passes.
    - If la_s becomes 0 while in FAIL (external clear), clear everything and go to IDLE.
- ack_edge during PULSE or VERIFY is ignored and is not queued. A held-high i_ack_req produces only one edge.
- LA changes during PULSE/VERIFY never alter o_first_idx; o_any_fault and o_fault_count keep tracking live.
- Asynchronous reset asserted mid-PULSE drops o_ff_reset to 0 immediately.
- The counter width is 8 bits.
- o_fault_count is a popcount of la_s; its maximum is N_FF, with no wrap.

Test Plan:
1. Reset, then set i_ff_la bit 5 only:
   - o_first_valid=1 and o_first_idx=5 three cycles later.
   - o_fault_count=1, o_any_fault=1.
2. Set bits 9 and 3 in the same cycle, then bit 0 ten cycles later:
   - o_first_idx=3.
   - o_fault_count goes 2 then 3; o_first_idx stays 3.
3. In FAULT, raise i_ack_req and model the latch card clearing on o_ff_reset:
   - o_ff_reset is high for exactly 16 cycles.
   - o_busy is high for 24 cycles.
   - Then o_first_valid=0, o_clear_fail=0, state IDLE.
4. Same as scenario 3, but bit 7 stays stuck:
   - After the verify, o_clear_fail=1 and o_first_idx is unchanged.
   - A second ack edge gives another 16-cycle pulse.
   - Releasing bit 7 during the second pulse results in o_clear_fail=0 and return to IDLE.
5. Toggle i_ack_req during PULSE, and toggle it while in IDLE:
   - No extra or extended pulse; pulse length remains exactly 16 cycles.
   - No pulse is issued from IDLE.
6. Drive reset=0 on cycle 5 of PULSE:
   - o_ff_reset=0 immediately and all outputs are 0.
   - After release with bit 2 still set, re-capture o_first_idx=2 in 3 cycles.

Source files
------------

// File: rtl/rpsc_fault_annunciator.sv
// First-fault annunciator for the fault latch cards: synchronizes the latched-alarm lines, captures
// the first fault, counts live faults and runs an acknowledged, verified reset of the latch cards.
module rpsc_fault_annunciator #(
  parameter int unsigned N_FF          = 48,
  parameter int unsigned RST_PULSE     = 16,
  parameter int unsigned VERIFY_CYCLES = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [N_FF-1:0]              i_ff_la,
  input  logic                         i_ack_req,
  output logic                         o_ff_reset,
  output logic                         o_any_fault,
  output logic [$clog2(N_FF+1)-1:0]    o_fault_count,
  output logic                         o_first_valid,
  output logic [$clog2(N_FF)-1:0]      o_first_idx,
  output logic                         o_busy,
  output logic                         o_clear_fail
);

  localparam int unsigned CntW = $clog2(N_FF + 1);
  localparam int unsigned IdxW = $clog2(N_FF);

  typedef enum logic [2:0] {
    StIdle,
    StFault,
    StPulse,
    StVerify,
    StFail
  } state_e;

  // Input synchronizers
  logic [N_FF-1:0] la_meta_q, la_s_q;
  logic            ack_meta_q, ack_s_q, ack_prev_q;
  logic            ack_edge;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      la_meta_q  <= '0;
      la_s_q     <= '0;
      ack_meta_q <= 1'b0;
      ack_s_q    <= 1'b0;
      ack_prev_q <= 1'b0;
    end else begin
      la_meta_q  <= i_ff_la;
      la_s_q     <= la_meta_q;
      ack_meta_q <= i_ack_req;
      ack_s_q    <= ack_meta_q;
      ack_prev_q <= ack_s_q;
    end
  end

  assign ack_edge = ack_s_q & ~ack_prev_q;

  // Live fault status
  logic            la_any;
  logic [CntW-1:0] la_count;
  logic [IdxW-1:0] low_idx;

  assign la_any = |la_s_q;

  always_comb begin
    la_count = '0;
    for (int i = 0; i < N_FF; i++) begin
      la_count = la_count + CntW'(la_s_q[i]);
    end
  end

  // Scanning from the top leaves the lowest set index in low_idx.
  always_comb begin
    low_idx = '0;
    for (int i = N_FF - 1; i >= 0; i--) begin
      if (la_s_q[i]) begin
        low_idx = IdxW'(i);
      end
    end
  end

  logic            any_q;
  logic [CntW-1:0] count_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      any_q   <= 1'b0;
      count_q <= '0;
    end else begin
      any_q   <= la_any;
      count_q <= la_count;
    end
  end

  // Sequencer
  state_e          state_q, state_d;
  logic [7:0]      cnt_q, cnt_d;
  logic            first_valid_q, first_valid_d;
  logic [IdxW-1:0] first_idx_q, first_idx_d;
  logic            clear_fail_q, clear_fail_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      first_valid_q <= 1'b0;
      first_idx_q   <= '0;
      clear_fail_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      first_valid_q <= first_valid_d;
      first_idx_q   <= first_idx_d;
      clear_fail_q  <= clear_fail_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    first_valid_d = first_valid_q;
    first_idx_d   = first_idx_q;
    clear_fail_d  = clear_fail_q;

    unique case (state_q)
      StIdle: begin
        if (la_any) begin
          first_valid_d = 1'b1;
          first_idx_d   = low_idx;
          state_d       = StFault;
        end
      end

      StFault: begin
        if (ack_edge) begin
          cnt_d   = 8'(RST_PULSE);
          state_d = StPulse;
        end
      end

      // Leaving on cnt_q == 1 keeps the state for exactly RST_PULSE cycles.
      StPulse: begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_q <= 8'd1) begin
          cnt_d   = 8'(VERIFY_CYCLES);
          state_d = StVerify;
        end
      end

      StVerify: begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_q <= 8'd1) begin
          cnt_d = '0;
          if (la_any) begin
            clear_fail_d = 1'b1;
            state_d      = StFail;
          end else begin
            first_valid_d = 1'b0;
            first_idx_d   = '0;
            clear_fail_d  = 1'b0;
            state_d       = StIdle;
          end
        end
      end

      // An external clear takes priority over a fresh acknowledge.
      StFail: begin
        if (!la_any) begin
          first_valid_d = 1'b0;
          first_idx_d   = '0;
          clear_fail_d  = 1'b0;
          state_d       = StIdle;
        end else if (ack_edge) begin
          cnt_d   = 8'(RST_PULSE);
          state_d = StPulse;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Decoded straight from the state register so an asynchronous reset drops the pulse at once.
  assign o_ff_reset    = (state_q == StPulse);
  assign o_busy        = (state_q == StPulse) || (state_q == StVerify);
  assign o_any_fault   = any_q;
  assign o_fault_count = count_q;
  assign o_first_valid = first_valid_q;
  assign o_first_idx   = first_idx_q;
  assign o_clear_fail  = clear_fail_q;

endmodule

// File: tb/tb_rpsc_fault_annunciator.sv
// Directed bench for rpsc_fault_annunciator: first-fault capture, counting, and the
// acknowledge / pulse / verify sequence with a simple latch-card model driven from the tasks.
module tb_rpsc_fault_annunciator;

  logic        clk;
  logic        reset;
  logic [47:0] ff_la;
  logic        ack_req;
  logic        ff_reset;
  logic        any_fault;
  logic [5:0]  fault_count;
  logic        first_valid;
  logic [5:0]  first_idx;
  logic        busy;
  logic        clear_fail;

  int total;
  int bad;

  rpsc_fault_annunciator #(
    .N_FF          (48),
    .RST_PULSE     (16),
    .VERIFY_CYCLES (8)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .i_ff_la       (ff_la),
    .i_ack_req     (ack_req),
    .o_ff_reset    (ff_reset),
    .o_any_fault   (any_fault),
    .o_fault_count (fault_count),
    .o_first_valid (first_valid),
    .o_first_idx   (first_idx),
    .o_busy        (busy),
    .o_clear_fail  (clear_fail)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Raises ack, counts pulse/busy cycles, and clears every latch not in keep on pulse cycle
  // release_at, as the latch cards would.
  task automatic run_ack(input logic [47:0] keep, input int release_at,
                         output int pc, output int bc);
    pc = 0;
    bc = 0;
    ack_req = 1'b1;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (ff_reset) begin
        pc++;
        if (pc == release_at) ff_la = ff_la & keep;
      end
      if (busy) bc++;
      else if (bc > 0) break;
    end
    ack_req = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    ff_la = '0;
    ack_req = 1'b0;
    repeat (3) tick();
    total++;
    if ({ff_reset, any_fault, fault_count, first_valid, first_idx, busy, clear_fail} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got=%b want=0",
               {ff_reset, any_fault, fault_count, first_valid, first_idx, busy, clear_fail});
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_single_fault();
    ff_la = 48'h0 | (48'h1 << 5);
    tick();
    tick();
    total++;
    if (first_valid !== 1'b0 || fault_count !== 6'd0) begin
      bad++;
      $display("FAIL early_capture got valid=%0d count=%0d want valid=0 count=0",
               first_valid, fault_count);
    end
    tick();
    total++;
    if (first_valid !== 1'b1 || first_idx !== 6'd5) begin
      bad++;
      $display("FAIL single_capture got valid=%0d idx=%0d want valid=1 idx=5",
               first_valid, first_idx);
    end
    total++;
    if (fault_count !== 6'd1 || any_fault !== 1'b1) begin
      bad++;
      $display("FAIL single_count got count=%0d any=%0d want count=1 any=1", fault_count, any_fault);
    end
  endtask

  task automatic test_tie_and_later();
    reset = 1'b0;
    ff_la = '0;
    tick();
    reset = 1'b1;
    tick();
    ff_la = (48'h1 << 9) | (48'h1 << 3);
    repeat (3) tick();
    total++;
    if (first_valid !== 1'b1 || first_idx !== 6'd3 || fault_count !== 6'd2) begin
      bad++;
      $display("FAIL tie_capture got valid=%0d idx=%0d count=%0d want valid=1 idx=3 count=2",
               first_valid, first_idx, fault_count);
    end
    repeat (7) tick();
    ff_la = ff_la | 48'h1;
    repeat (3) tick();
    total++;
    if (first_idx !== 6'd3 || fault_count !== 6'd3) begin
      bad++;
      $display("FAIL later_fault got idx=%0d count=%0d want idx=3 count=3", first_idx, fault_count);
    end
  endtask

  task automatic test_ack_clear();
    int pc, bc;
    run_ack(48'h0, 1, pc, bc);
    total++;
    if (pc !== 16) begin
      bad++;
      $display("FAIL clear_pulse_len got=%0d want=16", pc);
    end
    total++;
    if (bc !== 24) begin
      bad++;
      $display("FAIL clear_busy_len got=%0d want=24", bc);
    end
    total++;
    if (first_valid !== 1'b0 || clear_fail !== 1'b0 || first_idx !== 6'd0) begin
      bad++;
      $display("FAIL clear_result got valid=%0d fail=%0d idx=%0d want 0 0 0",
               first_valid, clear_fail, first_idx);
    end
    repeat (3) tick();
    total++;
    if (fault_count !== 6'd0 || any_fault !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL clear_idle got count=%0d any=%0d busy=%0d want 0 0 0",
               fault_count, any_fault, busy);
    end
  endtask

  task automatic test_stuck_latch();
    int pc, bc;
    ff_la = 48'h1 << 7;
    repeat (4) tick();
    total++;
    if (first_valid !== 1'b1 || first_idx !== 6'd7) begin
      bad++;
      $display("FAIL stuck_capture got valid=%0d idx=%0d want valid=1 idx=7", first_valid, first_idx);
    end
    run_ack(48'h1 << 7, 1, pc, bc);
    total++;
    if (pc !== 16 || bc !== 24) begin
      bad++;
      $display("FAIL stuck_pulse1 got pulse=%0d busy=%0d want 16 24", pc, bc);
    end
    total++;
    if (clear_fail !== 1'b1 || first_idx !== 6'd7 || first_valid !== 1'b1) begin
      bad++;
      $display("FAIL stuck_verify got fail=%0d idx=%0d valid=%0d want 1 7 1",
               clear_fail, first_idx, first_valid);
    end
    repeat (4) tick();
    run_ack(48'h0, 3, pc, bc);
    total++;
    if (pc !== 16 || bc !== 24) begin
      bad++;
      $display("FAIL stuck_pulse2 got pulse=%0d busy=%0d want 16 24", pc, bc);
    end
    total++;
    if (clear_fail !== 1'b0 || first_valid !== 1'b0) begin
      bad++;
      $display("FAIL stuck_release got fail=%0d valid=%0d want 0 0", clear_fail, first_valid);
    end
  endtask

  task automatic test_ack_ignored();
    int seen, pc, bc;
    seen = 0;
    repeat (4) tick();
    for (int r = 0; r < 3; r++) begin
      ack_req = 1'b1;
      repeat (3) begin tick(); if (ff_reset || busy) seen++; end
      ack_req = 1'b0;
      repeat (3) begin tick(); if (ff_reset || busy) seen++; end
    end
    total++;
    if (seen !== 0) begin
      bad++;
      $display("FAIL idle_ack got=%0d busy cycles want=0", seen);
    end
    ff_la = 48'h1 << 1;
    repeat (4) tick();
    pc = 0;
    bc = 0;
    ack_req = 1'b1;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (ff_reset) begin
        pc++;
        if (pc == 1) ff_la = '0;
        if (pc == 4) ack_req = 1'b0;
        if (pc == 6) ack_req = 1'b1;
        if (pc == 10) ack_req = 1'b0;
      end
      if (busy) bc++;
      else if (bc > 0) break;
    end
    ack_req = 1'b0;
    total++;
    if (pc !== 16 || bc !== 24) begin
      bad++;
      $display("FAIL toggle_pulse got pulse=%0d busy=%0d want 16 24", pc, bc);
    end
    seen = 0;
    repeat (10) begin tick(); if (ff_reset || busy) seen++; end
    total++;
    if (seen !== 0 || first_valid !== 1'b0) begin
      bad++;
      $display("FAIL toggle_queued got busy cycles=%0d valid=%0d want 0 0", seen, first_valid);
    end
  endtask

  task automatic test_reset_mid_pulse();
    int pc;
    ff_la = 48'h1 << 2;
    repeat (4) tick();
    pc = 0;
    ack_req = 1'b1;
    for (int i = 0; i < 50 && pc < 5; i++) begin
      tick();
      if (ff_reset) pc++;
    end
    total++;
    if (pc !== 5) begin
      bad++;
      $display("FAIL midpulse_reach got=%0d want=5", pc);
    end
    #2;
    reset = 1'b0;
    #1;
    total++;
    if ({ff_reset, any_fault, fault_count, first_valid, first_idx, busy, clear_fail} !== '0) begin
      bad++;
      $display("FAIL midpulse_reset got=%b want=0",
               {ff_reset, any_fault, fault_count, first_valid, first_idx, busy, clear_fail});
    end
    ack_req = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    tick();
    total++;
    if (first_valid !== 1'b0) begin
      bad++;
      $display("FAIL recapture_early got valid=%0d want 0", first_valid);
    end
    tick();
    total++;
    if (first_valid !== 1'b1 || first_idx !== 6'd2 || ff_reset !== 1'b0) begin
      bad++;
      $display("FAIL recapture got valid=%0d idx=%0d pulse=%0d want 1 2 0",
               first_valid, first_idx, ff_reset);
    end
  endtask

  task automatic test_full_count();
    ff_la = '1;
    repeat (3) tick();
    total++;
    if (fault_count !== 6'd48 || any_fault !== 1'b1 || first_idx !== 6'd2) begin
      bad++;
      $display("FAIL full_count got count=%0d any=%0d idx=%0d want 48 1 2",
               fault_count, any_fault, first_idx);
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    reset = 1'b0;
    ff_la = '0;
    ack_req = 1'b0;
    test_reset();
    test_single_fault();
    test_tie_and_later();
    test_ack_clear();
    test_stuck_latch();
    test_ack_ignored();
    test_reset_mid_pulse();
    test_full_count();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
